decoding_stage_pipelined: RTL and testbench
===========================================

# decoding_stage_pipelined

Parametrised RV32I decode stage with an integrated register file, placed between the fetch stage and the execution stage. It adds several things the single-cycle-stall decoder lacks:
- valid/ready handshakes on both sides instead of a bare stall input;
- same-cycle write-back bypass;
- automatic load-use interlock with bubble insertion;
- refresh of held operands while the stage is back-pressured.

All outputs come from a single pipeline register, so latency is one cycle.

## Interface
Parameters:
- XLEN, 32: datapath width. Legal values are 32 and 64. Immediates and PC are carried at XLEN.
- REG_COUNT, 32: number of architectural registers. Address width is 5; registers at or above REG_COUNT read as 0.
- BYPASS_EN, 1: enables write-back-to-read forwarding and held-operand refresh.

Ports (name, direction, width, meaning):
- CLK  in  1  clock; all state updates on the rising edge.
- RESET  in  1  reset; asynchronous, active-high.
- FLUSH  in  1  synchronous kill of the output register and the incoming instruction.
- IN_VALID  in  1  fetch presents an instruction.
- IN_READY  out  1  decode accepts this cycle.
- INSTRUCTION  in  32  raw instruction.
- PC_IN  in  XLEN  PC of INSTRUCTION.
- RD_ADDRESS_IN  in  5  write-back register address.
- RD_DATA_IN  in  XLEN  write-back data.
- RD_WRITE_ENABLE_IN  in  1  write-back strobe.
- OUT_VALID  out  1  output register holds a live instruction.
- OUT_READY  in  1  execute consumes this cycle.
- PC_OUT  out  XLEN  PC of the decoded instruction.
- RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT  out  5 each  register addresses.
- RS1_DATA, RS2_DATA  out  XLEN each  operand values.
- IMM_OUTPUT  out  XLEN  sign-extended immediate.
- ALU_INSTRUCTION  out  5  ALU operation code.
- ALU_INPUT_1_SELECT  out  1  0 selects rs1, 1 selects PC.
- ALU_INPUT_2_SELECT  out  1  0 selects rs2, 1 selects immediate.
- DATA_CACHE_LOAD  out  3  0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU.
- DATA_CACHE_STORE  out  2  0 none, 1 SB, 2 SH, 3 SW.
- WRITE_BACK_MUX_SELECT  out  1  1 selects load data, 0 selects ALU result.
- RD_WRITE_ENABLE_OUT  out  1  instruction writes rd.
- ILLEGAL_INSTRUCTION  out  1  opcode or funct field is not RV32I.

## Operation
- Register file:
  - x0 always reads 0; writes to x0 are ignored.
  - A write occurs on the rising edge when RD_WRITE_ENABLE_IN=1 and RD_ADDRESS_IN≠0.
- Bypass (BYPASS_EN=1): when a write-back targets a nonzero rs1/rs2 in the same cycle that the instruction is accepted, RD_DATA_IN is captured in place of the array value.
- Accept condition: IN_VALID & IN_READY.
  - IN_READY = FLUSH | ((~OUT_VALID | OUT_READY) & ~hazard).
- Hazard (load-use):
  - Condition: OUT_VALID=1, DATA_CACHE_LOAD≠0, RD_ADDRESS_OUT≠0, and RD_ADDRESS_OUT equals an rs field actually used by the incoming opcode. R, I, S and B formats use rs1; R, S and B use rs2.
  - Effect: when the load is consumed, the output register loads a bubble (OUT_VALID=0). The dependent instruction is accepted on the following cycle, giving a one-cycle penalty. No extra state beyond the output register is required.
- Hold refresh (BYPASS_EN=1): while OUT_VALID & ~OUT_READY, any write-back to a nonzero held RS1_ADDRESS/RS2_ADDRESS updates the corresponding RS*_DATA in the output register.
- Decode coverage: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - Immediate format is chosen by opcode (I/S/B/U/J).
  - The immediate is sign-extended to XLEN.
- Illegal instruction:
  - The instruction still goes out as valid, with ILLEGAL_INSTRUCTION=1.
  - RD_WRITE_ENABLE_OUT, DATA_CACHE_LOAD and DATA_CACHE_STORE are forced to 0.
- FLUSH:
  - Has priority over everything except RESET.
  - Next edge: OUT_VALID=0.
  - An instruction presented in the same cycle is dropped; IN_READY=1 so fetch does not stall.

## Timing
- Latency is one edge from acceptance to OUT_VALID=1. Sustained throughput is 1 instruction per cycle when there is no hazard and OUT_READY=1.
- The output register holds stable whenever OUT_VALID & ~OUT_READY. The only exception is hold refresh of RS*_DATA.
- Reset:
  - Asynchronous; clears OUT_VALID and every output-register field to 0.
  - Clears every register-file entry to 0.
  - While RESET=1, IN_READY=0.
  - When RESET asserts mid-stream, the in-flight instruction is lost.
- Write-back and refresh in the same cycle as consumption: a new instruction being accepted takes bypassed data. Refresh applies only to held data.
- FLUSH and hazard in the same cycle: FLUSH wins, with no bubble penalty.
- FLUSH asserted while the stage is back-pressured: the held instruction is killed regardless of OUT_READY.

## Structure
- Shared package risc_v_decode_pkg holds:
  - opcode constants;
  - funct3/funct7 constants;
  - ALU operation codes (5-bit);
  - load/store codes;
  - immediate-format enum.
- Sub-module register_file (parameters XLEN, REG_COUNT): two asynchronous read ports, one write port, and async reset. Bypass muxing lives in the parent.
- The decoder is combinational logic in the parent, feeding the output register.

## Test plan
- **Reset, then decode ADDI:** reset, then 0xfe010113 at PC 0x1. One cycle later:
  - OUT_VALID=1, PC_OUT=0x1;
  - RS1_ADDRESS=2, RD_ADDRESS_OUT=2;
  - IMM_OUTPUT=0xFFFFFFE0;
  - ALU_INPUT_2_SELECT=1, RD_WRITE_ENABLE_OUT=1, ILLEGAL_INSTRUCTION=0.
- **Store decode:** 0xfef42623 gives:
  - RS1_ADDRESS=8, RS2_ADDRESS=15;
  - IMM_OUTPUT=0xFFFFFFEC;
  - DATA_CACHE_STORE=3, RD_WRITE_ENABLE_OUT=0.
- **Same-cycle bypass:** write-back x2=0x1234 in the same cycle as accepting 0xfe010113 gives RS1_DATA=0x1234. A write-back x0=0x55 leaves x0 reading 0.
- **Load-use interlock:** `lw x5,0(x1)` then `add x6,x5,x7` with OUT_READY=1 gives:
  - IN_READY=0 for exactly one cycle;
  - one bubble (OUT_VALID=0);
  - then the add is output.
  - Repeating with `add x6,x7,x8` gives no bubble.
- **Hold refresh:** hold with OUT_READY=0 while RS1_ADDRESS=3, then write back x3=0xAA. RS1_DATA becomes 0xAA next cycle; all other fields are unchanged.
- **FLUSH and RESET mid-operation:**
  - FLUSH while held with IN_VALID=1: OUT_VALID=0 next edge and the new instruction is dropped.
  - RESET asserted between edges: OUT_VALID drops immediately, and a previously written register reads 0 afterwards.

Source files
------------

// File: rtl/risc_v_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU/load/store codes,
// immediate formats and the control word carried by the decode pipeline register.
package risc_v_decode_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_SLTU    = 3'b011;
   localparam logic [2:0] F3_XOR     = 3'b100;
   localparam logic [2:0] F3_SRL_SRA = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   localparam logic [2:0] F3_SB = 3'b000;
   localparam logic [2:0] F3_SH = 3'b001;
   localparam logic [2:0] F3_SW = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [4:0] ALU_ADD  = 5'd0;
   localparam logic [4:0] ALU_SUB  = 5'd1;
   localparam logic [4:0] ALU_SLL  = 5'd2;
   localparam logic [4:0] ALU_SLT  = 5'd3;
   localparam logic [4:0] ALU_SLTU = 5'd4;
   localparam logic [4:0] ALU_XOR  = 5'd5;
   localparam logic [4:0] ALU_SRL  = 5'd6;
   localparam logic [4:0] ALU_SRA  = 5'd7;
   localparam logic [4:0] ALU_OR   = 5'd8;
   localparam logic [4:0] ALU_AND  = 5'd9;
   localparam logic [4:0] ALU_LUI  = 5'd10;
   localparam logic [4:0] ALU_BEQ  = 5'd11;
   localparam logic [4:0] ALU_BNE  = 5'd12;
   localparam logic [4:0] ALU_BLT  = 5'd13;
   localparam logic [4:0] ALU_BGE  = 5'd14;
   localparam logic [4:0] ALU_BLTU = 5'd15;
   localparam logic [4:0] ALU_BGEU = 5'd16;

   localparam logic [2:0] LD_NONE = 3'd0;
   localparam logic [2:0] LD_LB   = 3'd1;
   localparam logic [2:0] LD_LH   = 3'd2;
   localparam logic [2:0] LD_LW   = 3'd3;
   localparam logic [2:0] LD_LBU  = 3'd4;
   localparam logic [2:0] LD_LHU  = 3'd5;

   localparam logic [1:0] ST_NONE = 2'd0;
   localparam logic [1:0] ST_SB   = 2'd1;
   localparam logic [1:0] ST_SH   = 2'd2;
   localparam logic [1:0] ST_SW   = 2'd3;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_format_t;

   typedef struct packed {
      logic [4:0] alu_op;
      logic       alu_sel1;
      logic       alu_sel2;
      logic [2:0] load;
      logic [1:0] store;
      logic       wb_sel;
      logic       rd_we;
      logic       illegal;
   } ctrl_t;

   localparam ctrl_t CTRL_ILLEGAL = '{alu_op: ALU_ADD, alu_sel1: 1'b0, alu_sel2: 1'b0,
                                      load: LD_NONE, store: ST_NONE, wb_sel: 1'b0,
                                      rd_we: 1'b0, illegal: 1'b1};

   function automatic logic [31:0] extract_imm(input logic [31:0] instr, input imm_format_t fmt);
      logic [31:0] imm;
      case (fmt)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'h000};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = 32'h0000_0000;
      endcase
      return imm;
   endfunction

   // shared by OP and OP-IMM; alt selects SUB/SRA
   function automatic logic [4:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
      logic [4:0] op;
      case (f3)
         F3_ADD_SUB: op = alt ? ALU_SUB : ALU_ADD;
         F3_SLL:     op = ALU_SLL;
         F3_SLT:     op = ALU_SLT;
         F3_SLTU:    op = ALU_SLTU;
         F3_XOR:     op = ALU_XOR;
         F3_SRL_SRA: op = alt ? ALU_SRA : ALU_SRL;
         F3_OR:      op = ALU_OR;
         F3_AND:     op = ALU_AND;
         default:    op = ALU_ADD;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/register_file.sv
// Architectural register file: two asynchronous read ports, one write port,
// x0 and out-of-range addresses read as zero.
module register_file
   import risc_v_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  write_enable,
   input  logic [REG_ADDR_W-1:0] write_address,
   input  logic [XLEN-1:0]       write_data,
   input  logic [REG_ADDR_W-1:0] read_address_1,
   output logic [XLEN-1:0]       read_data_1,
   input  logic [REG_ADDR_W-1:0] read_address_2,
   output logic [XLEN-1:0]       read_data_2
);

   localparam logic [REG_ADDR_W:0] REG_LIMIT = (REG_ADDR_W + 1)'(REG_COUNT);

   logic [XLEN-1:0] regs [REG_COUNT];
   logic            write_ok;
   logic            read_ok_1;
   logic            read_ok_2;

   assign write_ok  = write_enable && (write_address != 5'd0) && ({1'b0, write_address} < REG_LIMIT);
   assign read_ok_1 = (read_address_1 != 5'd0) && ({1'b0, read_address_1} < REG_LIMIT);
   assign read_ok_2 = (read_address_2 != 5'd0) && ({1'b0, read_address_2} < REG_LIMIT);

   assign read_data_1 = read_ok_1 ? regs[read_address_1] : '0;
   assign read_data_2 = read_ok_2 ? regs[read_address_2] : '0;

   // register array with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < REG_COUNT; i++) begin
            regs[i] <= '0;
         end
      end else if (write_ok) begin
         regs[write_address] <= write_data;
      end
   end

endmodule

// File: rtl/decoding_stage_pipelined.sv
// RV32I decode stage: combinational decoder and register read feeding a single
// output register, with valid/ready handshakes, write-back bypass and load-use interlock.
module decoding_stage_pipelined
   import risc_v_decode_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int REG_COUNT = 32,
   parameter int BYPASS_EN = 1
) (
   input  logic            CLK,
   input  logic            RESET,
   input  logic            FLUSH,
   input  logic            IN_VALID,
   output logic            IN_READY,
   input  logic [31:0]     INSTRUCTION,
   input  logic [XLEN-1:0] PC_IN,
   input  logic [4:0]      RD_ADDRESS_IN,
   input  logic [XLEN-1:0] RD_DATA_IN,
   input  logic            RD_WRITE_ENABLE_IN,
   output logic            OUT_VALID,
   input  logic            OUT_READY,
   output logic [XLEN-1:0] PC_OUT,
   output logic [4:0]      RS1_ADDRESS,
   output logic [4:0]      RS2_ADDRESS,
   output logic [4:0]      RD_ADDRESS_OUT,
   output logic [XLEN-1:0] RS1_DATA,
   output logic [XLEN-1:0] RS2_DATA,
   output logic [XLEN-1:0] IMM_OUTPUT,
   output logic [4:0]      ALU_INSTRUCTION,
   output logic            ALU_INPUT_1_SELECT,
   output logic            ALU_INPUT_2_SELECT,
   output logic [2:0]      DATA_CACHE_LOAD,
   output logic [1:0]      DATA_CACHE_STORE,
   output logic            WRITE_BACK_MUX_SELECT,
   output logic            RD_WRITE_ENABLE_OUT,
   output logic            ILLEGAL_INSTRUCTION
);

   localparam logic BYPASS = (BYPASS_EN != 0);

   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [4:0]        rs1_field;
   logic [4:0]        rs2_field;
   logic [4:0]        rd_field;
   imm_format_t       fmt;
   ctrl_t             raw_ctrl;
   ctrl_t             dec_ctrl;
   ctrl_t             ctrl_r;
   logic              legal;
   logic              uses_rs1;
   logic              uses_rs2;
   logic signed [31:0] imm32;
   logic [XLEN-1:0]   imm_ext;
   logic [XLEN-1:0]   rf_rs1;
   logic [XLEN-1:0]   rf_rs2;
   logic [XLEN-1:0]   rs1_value;
   logic [XLEN-1:0]   rs2_value;
   logic              wb_active;
   logic              hazard;
   logic              advance;
   logic              accept;

   assign opcode    = INSTRUCTION[6:0];
   assign funct3    = INSTRUCTION[14:12];
   assign funct7    = INSTRUCTION[31:25];
   assign rs1_field = INSTRUCTION[19:15];
   assign rs2_field = INSTRUCTION[24:20];
   assign rd_field  = INSTRUCTION[11:7];

   // opcode/funct decode into control word, immediate format and rs usage
   always_comb begin
      raw_ctrl          = '0;
      raw_ctrl.alu_op   = ALU_ADD;
      fmt               = IMM_NONE;
      legal             = 1'b1;
      uses_rs1          = 1'b0;
      uses_rs2          = 1'b0;
      case (opcode)
         OPC_LUI: begin
            fmt = IMM_U;
            raw_ctrl.alu_op = ALU_LUI;
            raw_ctrl.alu_sel2 = 1'b1;
            raw_ctrl.rd_we = 1'b1;
         end
         OPC_AUIPC, OPC_JAL: begin
            fmt = (opcode == OPC_JAL) ? IMM_J : IMM_U;
            raw_ctrl.alu_sel1 = 1'b1;
            raw_ctrl.alu_sel2 = 1'b1;
            raw_ctrl.rd_we = 1'b1;
         end
         OPC_JALR: begin
            fmt = IMM_I;
            uses_rs1 = 1'b1;
            raw_ctrl.alu_sel2 = 1'b1;
            raw_ctrl.rd_we = 1'b1;
            legal = (funct3 == 3'b000);
         end
         OPC_BRANCH: begin
            fmt = IMM_B;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            case (funct3)
               F3_BEQ:  raw_ctrl.alu_op = ALU_BEQ;
               F3_BNE:  raw_ctrl.alu_op = ALU_BNE;
               F3_BLT:  raw_ctrl.alu_op = ALU_BLT;
               F3_BGE:  raw_ctrl.alu_op = ALU_BGE;
               F3_BLTU: raw_ctrl.alu_op = ALU_BLTU;
               F3_BGEU: raw_ctrl.alu_op = ALU_BGEU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LOAD: begin
            fmt = IMM_I;
            uses_rs1 = 1'b1;
            raw_ctrl.alu_sel2 = 1'b1;
            raw_ctrl.wb_sel = 1'b1;
            raw_ctrl.rd_we = 1'b1;
            case (funct3)
               F3_LB:   raw_ctrl.load = LD_LB;
               F3_LH:   raw_ctrl.load = LD_LH;
               F3_LW:   raw_ctrl.load = LD_LW;
               F3_LBU:  raw_ctrl.load = LD_LBU;
               F3_LHU:  raw_ctrl.load = LD_LHU;
               default: legal = 1'b0;
            endcase
         end
         OPC_STORE: begin
            fmt = IMM_S;
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            raw_ctrl.alu_sel2 = 1'b1;
            case (funct3)
               F3_SB:   raw_ctrl.store = ST_SB;
               F3_SH:   raw_ctrl.store = ST_SH;
               F3_SW:   raw_ctrl.store = ST_SW;
               default: legal = 1'b0;
            endcase
         end
         OPC_OP_IMM: begin
            fmt = IMM_I;
            uses_rs1 = 1'b1;
            raw_ctrl.alu_sel2 = 1'b1;
            raw_ctrl.rd_we = 1'b1;
            // only shifts carry a funct7; ADDI with those bits set stays ADDI
            raw_ctrl.alu_op = alu_from_funct3(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
            if (funct3 == F3_SLL) begin
               legal = (funct7 == F7_BASE);
            end else if (funct3 == F3_SRL_SRA) begin
               legal = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            end else begin
               legal = 1'b1;
            end
         end
         OPC_OP: begin
            uses_rs1 = 1'b1;
            uses_rs2 = 1'b1;
            raw_ctrl.rd_we = 1'b1;
            raw_ctrl.alu_op = alu_from_funct3(funct3, funct7 == F7_ALT);
            legal = (funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA)));
         end
         default: legal = 1'b0;
      endcase
   end

   assign dec_ctrl = legal ? raw_ctrl : CTRL_ILLEGAL;
   assign imm32    = extract_imm(INSTRUCTION, fmt);
   assign imm_ext  = XLEN'(imm32);

   register_file #(
      .XLEN      (XLEN),
      .REG_COUNT (REG_COUNT)
   ) u_register_file (
      .clk            (CLK),
      .rst            (RESET),
      .write_enable   (RD_WRITE_ENABLE_IN),
      .write_address  (RD_ADDRESS_IN),
      .write_data     (RD_DATA_IN),
      .read_address_1 (rs1_field),
      .read_data_1    (rf_rs1),
      .read_address_2 (rs2_field),
      .read_data_2    (rf_rs2)
   );

   assign wb_active = RD_WRITE_ENABLE_IN && (RD_ADDRESS_IN != 5'd0);
   assign rs1_value = (BYPASS && wb_active && (RD_ADDRESS_IN == rs1_field)) ? RD_DATA_IN : rf_rs1;
   assign rs2_value = (BYPASS && wb_active && (RD_ADDRESS_IN == rs2_field)) ? RD_DATA_IN : rf_rs2;

   // load in the output register whose rd feeds a source of the incoming instruction
   assign hazard = OUT_VALID && (ctrl_r.load != LD_NONE) && (RD_ADDRESS_OUT != 5'd0) &&
                   ((uses_rs1 && (rs1_field == RD_ADDRESS_OUT)) ||
                    (uses_rs2 && (rs2_field == RD_ADDRESS_OUT)));

   assign advance  = !OUT_VALID || OUT_READY;
   assign IN_READY = !RESET && (FLUSH || (advance && !hazard));
   assign accept   = IN_VALID && IN_READY && !FLUSH;

   // output pipeline register: flush, advance (new instruction or bubble), or hold with refresh
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         OUT_VALID      <= 1'b0;
         PC_OUT         <= '0;
         RS1_ADDRESS    <= 5'd0;
         RS2_ADDRESS    <= 5'd0;
         RD_ADDRESS_OUT <= 5'd0;
         RS1_DATA       <= '0;
         RS2_DATA       <= '0;
         IMM_OUTPUT     <= '0;
         ctrl_r         <= '0;
      end else if (FLUSH) begin
         OUT_VALID <= 1'b0;
      end else if (advance) begin
         OUT_VALID <= accept;
         if (accept) begin
            PC_OUT         <= PC_IN;
            RS1_ADDRESS    <= rs1_field;
            RS2_ADDRESS    <= rs2_field;
            RD_ADDRESS_OUT <= rd_field;
            RS1_DATA       <= rs1_value;
            RS2_DATA       <= rs2_value;
            IMM_OUTPUT     <= imm_ext;
            ctrl_r         <= dec_ctrl;
         end
      end else begin
         if (BYPASS && wb_active && (RD_ADDRESS_IN == RS1_ADDRESS)) begin
            RS1_DATA <= RD_DATA_IN;
         end
         if (BYPASS && wb_active && (RD_ADDRESS_IN == RS2_ADDRESS)) begin
            RS2_DATA <= RD_DATA_IN;
         end
      end
   end

   assign ALU_INSTRUCTION       = ctrl_r.alu_op;
   assign ALU_INPUT_1_SELECT    = ctrl_r.alu_sel1;
   assign ALU_INPUT_2_SELECT    = ctrl_r.alu_sel2;
   assign DATA_CACHE_LOAD       = ctrl_r.load;
   assign DATA_CACHE_STORE      = ctrl_r.store;
   assign WRITE_BACK_MUX_SELECT = ctrl_r.wb_sel;
   assign RD_WRITE_ENABLE_OUT   = ctrl_r.rd_we;
   assign ILLEGAL_INSTRUCTION   = ctrl_r.illegal;

endmodule

// File: tb/tb_decoding_stage_pipelined.sv
// Directed bench for decoding_stage_pipelined: a decode vector table followed by
// hand-written bypass, interlock, hold-refresh, flush and reset sequences.
module tb_decoding_stage_pipelined;
   import risc_v_decode_pkg::*;

   logic        CLK = 1'b0;
   logic        RESET, FLUSH, IN_VALID, IN_READY;
   logic [31:0] INSTRUCTION, PC_IN, RD_DATA_IN;
   logic [4:0]  RD_ADDRESS_IN;
   logic        RD_WRITE_ENABLE_IN, OUT_VALID, OUT_READY;
   logic [31:0] PC_OUT, RS1_DATA, RS2_DATA, IMM_OUTPUT;
   logic [4:0]  RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT, ALU_INSTRUCTION;
   logic        ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, WRITE_BACK_MUX_SELECT;
   logic [2:0]  DATA_CACHE_LOAD;
   logic [1:0]  DATA_CACHE_STORE;
   logic        RD_WRITE_ENABLE_OUT, ILLEGAL_INSTRUCTION;

   int errors = 0;
   int checks = 0;

   localparam logic [31:0] LW_X5    = 32'h0000A283;
   localparam logic [31:0] ADD_DEP  = 32'h00728333;
   localparam logic [31:0] ADD_IND  = 32'h00838333;
   localparam logic [31:0] ADDI_X3  = 32'h00118213;
   localparam logic [31:0] ADDI_X2  = 32'hfe010113;

   decoding_stage_pipelined #(.XLEN(32), .REG_COUNT(32), .BYPASS_EN(1)) dut (
      .CLK(CLK), .RESET(RESET), .FLUSH(FLUSH), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
      .INSTRUCTION(INSTRUCTION), .PC_IN(PC_IN), .RD_ADDRESS_IN(RD_ADDRESS_IN),
      .RD_DATA_IN(RD_DATA_IN), .RD_WRITE_ENABLE_IN(RD_WRITE_ENABLE_IN),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .PC_OUT(PC_OUT),
      .RS1_ADDRESS(RS1_ADDRESS), .RS2_ADDRESS(RS2_ADDRESS), .RD_ADDRESS_OUT(RD_ADDRESS_OUT),
      .RS1_DATA(RS1_DATA), .RS2_DATA(RS2_DATA), .IMM_OUTPUT(IMM_OUTPUT),
      .ALU_INSTRUCTION(ALU_INSTRUCTION), .ALU_INPUT_1_SELECT(ALU_INPUT_1_SELECT),
      .ALU_INPUT_2_SELECT(ALU_INPUT_2_SELECT), .DATA_CACHE_LOAD(DATA_CACHE_LOAD),
      .DATA_CACHE_STORE(DATA_CACHE_STORE), .WRITE_BACK_MUX_SELECT(WRITE_BACK_MUX_SELECT),
      .RD_WRITE_ENABLE_OUT(RD_WRITE_ENABLE_OUT), .ILLEGAL_INSTRUCTION(ILLEGAL_INSTRUCTION)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] imm;
      logic [4:0]  alu;
      logic        sel1, sel2;
      logic [2:0]  load;
      logic [1:0]  store;
      logic        wb, we, ill;
   } vec_t;

   vec_t vecs [12];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      vecs[0]  = '{32'hfe010113, 32'h1,  5'd2,  5'd0,  5'd2,  32'hFFFFFFE0, ALU_ADD,  1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[1]  = '{32'hfef42623, 32'h5,  5'd8,  5'd15, 5'd12, 32'hFFFFFFEC, ALU_ADD,  1'b0, 1'b1, 3'd0, 2'd3, 1'b0, 1'b0, 1'b0};
      vecs[2]  = '{32'h123450B7, 32'h9,  5'd8,  5'd3,  5'd1,  32'h12345000, ALU_LUI,  1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[3]  = '{32'hFFFFF197, 32'hC,  5'd31, 5'd31, 5'd3,  32'hFFFFF000, ALU_ADD,  1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[4]  = '{32'hFFDFF0EF, 32'h10, 5'd31, 5'd29, 5'd1,  32'hFFFFFFFC, ALU_ADD,  1'b1, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[5]  = '{32'h00208463, 32'h14, 5'd1,  5'd2,  5'd8,  32'h00000008, ALU_BEQ,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b0};
      vecs[6]  = '{32'h40335293, 32'h18, 5'd6,  5'd3,  5'd5,  32'h00000403, ALU_SRA,  1'b0, 1'b1, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{32'h00414203, 32'h1C, 5'd2,  5'd4,  5'd4,  32'h00000004, ALU_ADD,  1'b0, 1'b1, 3'd4, 2'd0, 1'b1, 1'b1, 1'b0};
      vecs[8]  = '{32'h00728333, 32'h20, 5'd5,  5'd7,  5'd6,  32'h00000000, ALU_ADD,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1, 1'b0};
      vecs[9]  = '{32'h400090B3, 32'h24, 5'd1,  5'd0,  5'd1,  32'h00000000, ALU_ADD,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[10] = '{32'hFFFFFFFF, 32'h28, 5'd31, 5'd31, 5'd31, 32'h00000000, ALU_ADD,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1};
      vecs[11] = '{32'h0000B283, 32'h2C, 5'd1,  5'd0,  5'd5,  32'h00000000, ALU_ADD,  1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0, 1'b1};

      RESET = 1'b1; FLUSH = 1'b0; IN_VALID = 1'b0; INSTRUCTION = 32'h0; PC_IN = 32'h0;
      RD_ADDRESS_IN = 5'd0; RD_DATA_IN = 32'h0; RD_WRITE_ENABLE_IN = 1'b0; OUT_READY = 1'b1;
      #12;
      check("reset out_valid", OUT_VALID, 1'b0);
      check("reset in_ready", IN_READY, 1'b0);
      check("reset pc_out", PC_OUT, 32'h0);
      check("reset imm", IMM_OUTPUT, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;

      // decode table, one instruction per cycle
      for (int i = 0; i < 12; i++) begin
         IN_VALID = 1'b1; INSTRUCTION = vecs[i].instr; PC_IN = vecs[i].pc;
         tick();
         check($sformatf("v%0d out_valid", i), OUT_VALID, 1'b1);
         check($sformatf("v%0d pc", i), PC_OUT, vecs[i].pc);
         check($sformatf("v%0d regs", i), {RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT},
               {vecs[i].rs1, vecs[i].rs2, vecs[i].rd});
         check($sformatf("v%0d imm", i), IMM_OUTPUT, vecs[i].imm);
         check($sformatf("v%0d ctrl", i),
               {ALU_INSTRUCTION, ALU_INPUT_1_SELECT, ALU_INPUT_2_SELECT, DATA_CACHE_LOAD,
                DATA_CACHE_STORE, WRITE_BACK_MUX_SELECT, RD_WRITE_ENABLE_OUT, ILLEGAL_INSTRUCTION},
               {vecs[i].alu, vecs[i].sel1, vecs[i].sel2, vecs[i].load, vecs[i].store,
                vecs[i].wb, vecs[i].we, vecs[i].ill});
      end

      // same-cycle bypass and x0 handling
      INSTRUCTION = ADDI_X2; PC_IN = 32'h100;
      RD_WRITE_ENABLE_IN = 1'b1; RD_ADDRESS_IN = 5'd2; RD_DATA_IN = 32'h1234;
      tick();
      check("bypass x2", RS1_DATA, 32'h1234);
      INSTRUCTION = 32'h00500093; RD_ADDRESS_IN = 5'd0; RD_DATA_IN = 32'h55;
      tick();
      check("bypass x0", RS1_DATA, 32'h0);
      RD_WRITE_ENABLE_IN = 1'b0;
      tick();
      check("array x0", RS1_DATA, 32'h0);
      INSTRUCTION = ADDI_X2;
      tick();
      check("array x2", RS1_DATA, 32'h1234);

      // load-use interlock: one bubble
      INSTRUCTION = LW_X5;
      tick();
      check("lw load code", DATA_CACHE_LOAD, LD_LW);
      INSTRUCTION = ADD_DEP;
      #1;
      check("hazard in_ready", IN_READY, 1'b0);
      tick();
      check("bubble", OUT_VALID, 1'b0);
      check("ready after bubble", IN_READY, 1'b1);
      tick();
      check("dep add valid", OUT_VALID, 1'b1);
      check("dep add regs", {RS1_ADDRESS, RS2_ADDRESS, RD_ADDRESS_OUT}, {5'd5, 5'd7, 5'd6});

      // no dependency: no bubble
      INSTRUCTION = LW_X5;
      tick();
      INSTRUCTION = ADD_IND;
      #1;
      check("no hazard in_ready", IN_READY, 1'b1);
      tick();
      check("ind add valid", OUT_VALID, 1'b1);
      check("ind add rs", {RS1_ADDRESS, RS2_ADDRESS}, {5'd7, 5'd8});

      // hold refresh of RS1_DATA
      INSTRUCTION = ADDI_X3; PC_IN = 32'h200;
      tick();
      check("hold rs1 addr", RS1_ADDRESS, 5'd3);
      OUT_READY = 1'b0; INSTRUCTION = ADD_DEP; PC_IN = 32'h204;
      RD_WRITE_ENABLE_IN = 1'b1; RD_ADDRESS_IN = 5'd3; RD_DATA_IN = 32'hAA;
      #1;
      check("held in_ready", IN_READY, 1'b0);
      tick();
      RD_WRITE_ENABLE_IN = 1'b0;
      check("refresh rs1", RS1_DATA, 32'hAA);
      check("refresh fields", {OUT_VALID, PC_OUT, RD_ADDRESS_OUT, IMM_OUTPUT, RS2_DATA},
            {1'b1, 32'h200, 5'd4, 32'h1, 32'h0});
      tick();
      check("still held", {RS1_DATA, PC_OUT}, {32'hAA, 32'h200});

      // flush while back-pressured drops held and incoming instructions
      FLUSH = 1'b1;
      #1;
      check("flush in_ready", IN_READY, 1'b1);
      tick();
      FLUSH = 1'b0; IN_VALID = 1'b0;
      check("flush kills held", OUT_VALID, 1'b0);
      tick();
      check("flush drops new", OUT_VALID, 1'b0);
      OUT_READY = 1'b1;

      // flush beats hazard: no bubble penalty
      IN_VALID = 1'b1; INSTRUCTION = LW_X5;
      tick();
      INSTRUCTION = ADD_DEP; FLUSH = 1'b1;
      #1;
      check("flush+hazard ready", IN_READY, 1'b1);
      tick();
      FLUSH = 1'b0;
      check("flush+hazard valid", OUT_VALID, 1'b0);
      tick();
      check("after flush add", {OUT_VALID, RD_ADDRESS_OUT}, {1'b1, 5'd6});

      // asynchronous reset mid-stream clears pipeline and register file
      INSTRUCTION = ADDI_X3;
      tick();
      check("x3 before reset", RS1_DATA, 32'hAA);
      #2 RESET = 1'b1;
      #1;
      check("async reset valid", OUT_VALID, 1'b0);
      check("async reset ready", IN_READY, 1'b0);
      check("async reset data", RS1_DATA, 32'h0);
      @(negedge CLK);
      RESET = 1'b0;
      tick();
      check("x3 after reset", {OUT_VALID, RS1_DATA}, {1'b1, 32'h0});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
